reg_triplet_serializer: RTL and testbench

- Downstream consumer of the three-lane 8-bit register bank (q0/q1/q2).
- Captures a three-byte triplet with a valid/ready handshake and replays the enabled lanes one byte per cycle on a single byte stream.
- Each output byte carries its lane tag and an end-of-frame marker.
- Counts emitted frames and dropped (all-lanes-masked) frames for debug.

---
 rtl/reg_triplet_serializer_pkg.sv | 18 +
 rtl/reg_triplet_serializer_lowest_set_lane.sv | 22 ++
 rtl/reg_triplet_serializer.sv | 123 ++++++++++++
 tb/tb_reg_triplet_serializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_triplet_serializer_pkg.sv
// Shared types and constants for the triplet serializer and its lane scanner.
package reg_triplet_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   localparam int LANES  = 3;
   localparam int LANE_W = 2;

   function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
      logic [LANES-1:0] bit0;
      bit0 = LANES'(1);
      return bit0 << lane;
   endfunction

endpackage

// File: rtl/reg_triplet_serializer_lowest_set_lane.sv
// Priority encoder: lowest set lane of a mask, and whether it is the only one left.
module lowest_set_lane
   import reg_triplet_serializer_pkg::*;
(
   input  logic [LANES-1:0]  mask,
   output logic [LANE_W-1:0] lane,
   output logic              is_last
);

   always_comb begin
      lane = '0;
      if (mask[0]) begin
         lane = LANE_W'(0);
      end else if (mask[1]) begin
         lane = LANE_W'(1);
      end else if (mask[2]) begin
         lane = LANE_W'(2);
      end
      is_last = (mask != '0) && ((mask & ~lane_onehot(lane)) == '0);
   end

endmodule

// File: rtl/reg_triplet_serializer.sv
// Captures a three-lane triplet and replays the enabled lanes as a tagged byte stream.
module reg_triplet_serializer
   import reg_triplet_serializer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [2:0]       lane_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_lane,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_e                       state_q, state_d;
   logic [LANES-1:0]             mask_q, mask_d;
   logic [LANES-1:0][WIDTH-1:0]  hold_q, hold_d;
   logic                         out_valid_q, out_valid_d;
   logic [WIDTH-1:0]             out_data_q, out_data_d;
   logic [LANE_W-1:0]            out_lane_q, out_lane_d;
   logic                         out_last_q, out_last_d;
   logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;

   logic [LANE_W-1:0]            nxt_lane;
   logic                         nxt_last;
   logic                         accept;
   logic                         out_fire;

   // Scanning the next-cycle mask lets the output byte be registered with no extra latency.
   lowest_set_lane u_scan (
      .mask    (mask_d),
      .lane    (nxt_lane),
      .is_last (nxt_last)
   );

   assign in_ready = (state_q == ST_IDLE) || (out_last_q && out_ready);
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      hold_d      = hold_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;

      if (out_fire) begin
         mask_d = mask_q & ~lane_onehot(out_lane_q);
         if (out_last_q) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = ST_IDLE;
         end
      end

      // A capture on the final handshake overrides the return to IDLE: no bubble.
      if (accept) begin
         if (lane_mask != '0) begin
            hold_d  = {d2, d1, d0};
            mask_d  = lane_mask;
            state_d = ST_SEND;
         end else begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
      end

      out_valid_d = (state_d == ST_SEND);
      out_lane_d  = '0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      if (out_valid_d) begin
         out_lane_d = nxt_lane;
         out_last_d = nxt_last;
         case (nxt_lane)
            LANE_W'(1): out_data_d = hold_d[1];
            LANE_W'(2): out_data_d = hold_d[2];
            default:    out_data_d = hold_d[0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mask_q      <= '0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_last_q  <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_last_q  <= out_last_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_last  = out_last_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_reg_triplet_serializer.sv
// Bench for reg_triplet_serializer: table vectors, scoreboard of expected bytes, corner sequences.
module tb_reg_triplet_serializer;

   typedef struct packed {
      logic [2:0]      mask;
      logic [2:0][7:0] d;
      int              n;
      logic [2:0][1:0] lane;
      logic [2:0][7:0] dat;
   } vec_t;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] lane;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready;
   logic [7:0] d0, d1, d2;
   logic [2:0] lane_mask;
   logic       in_ready, out_valid, out_last;
   logic [7:0] out_data;
   logic [1:0] out_lane;
   logic [15:0] frame_cnt, drop_cnt;
   logic       in_ready_w, out_valid_w, out_last_w;
   logic [7:0] out_data_w;
   logic [1:0] out_lane_w;
   logic [1:0] frame_cnt_w, drop_cnt_w;

   int   tests = 0;
   int   fails = 0;
   int   exp_frames = 0;
   int   exp_drops = 0;
   exp_t sb[$];

   logic       prev_stall;
   logic [7:0] prev_data;
   logic [1:0] prev_lane;
   logic       prev_last;

   always #5 clk = ~clk;

   reg_triplet_serializer #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .d0(d0), .d1(d1), .d2(d2), .lane_mask(lane_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_lane(out_lane), .out_last(out_last),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   reg_triplet_serializer #(.WIDTH(8), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .d0(d0), .d1(d1), .d2(d2), .lane_mask(lane_mask),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
      .out_lane(out_lane_w), .out_last(out_last_w),
      .frame_cnt(frame_cnt_w), .drop_cnt(drop_cnt_w)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   task automatic pop_and_check();
      exp_t e;
      if (sb.size() == 0) begin
         fail_now("unexpected_byte");
      end else begin
         e = sb.pop_front();
         chk("out_data", 32'(out_data), 32'(e.data));
         chk("out_lane", 32'(out_lane), 32'(e.lane));
         chk("out_last", 32'(out_last), 32'(e.last));
      end
   endtask

   // Output monitor: consumes the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         chk("wrap_inst_match", 32'({in_ready_w, out_valid_w, out_last_w, out_lane_w, out_data_w}),
             32'({in_ready, out_valid, out_last, out_lane, out_data}));
         if (prev_stall) begin
            chk("stall_hold", 32'({out_valid, out_last, out_lane, out_data}),
                32'({1'b1, prev_last, prev_lane, prev_data}));
         end
         if (out_valid && out_ready) pop_and_check();
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
         prev_lane  <= out_lane;
         prev_last  <= out_last;
      end
   end

   function automatic vec_t mk(input logic [2:0] m, input logic [7:0] a, b, c, input int n,
                               input logic [1:0] l0, l1, l2, input logic [7:0] b0, b1, b2);
      vec_t v;
      v.mask = m;
      v.d    = {c, b, a};
      v.n    = n;
      v.lane = {l2, l1, l0};
      v.dat  = {b2, b1, b0};
      return v;
   endfunction

   // Called and returns at posedge+1; leaves in_valid high so a following send can chain.
   task automatic send(input vec_t v);
      bit   acc = 1'b0;
      exp_t e;
      in_valid  = 1'b1;
      lane_mask = v.mask;
      d0 = v.d[0];
      d1 = v.d[1];
      d2 = v.d[2];
      for (int i = 0; i < 60 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         fail_now("send_timeout");
      end else begin
         for (int k = 0; k < v.n; k++) begin
            e.data = v.dat[k];
            e.lane = v.lane[k];
            e.last = (k == v.n - 1);
            sb.push_back(e);
         end
         if (v.n == 0) exp_drops++;
         else exp_frames++;
      end
   endtask

   task automatic idle_in();
      in_valid  = 1'b0;
      d0        = 8'($urandom);
      d1        = 8'($urandom);
      d2        = 8'($urandom);
      lane_mask = 3'($urandom);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !out_valid;
      end
      if (!done) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   vec_t tab[8];

   initial begin
      tab[0] = mk(3'b111, 8'h01, 8'h0F, 8'hF0, 3, 0, 1, 2, 8'h01, 8'h0F, 8'hF0);
      tab[1] = mk(3'b010, 8'h00, 8'hFF, 8'h00, 1, 1, 0, 0, 8'hFF, 8'h00, 8'h00);
      tab[2] = mk(3'b101, 8'h11, 8'hAA, 8'h22, 2, 0, 2, 0, 8'h11, 8'h22, 8'h00);
      tab[3] = mk(3'b000, 8'hDE, 8'hAD, 8'hBE, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      tab[4] = mk(3'b110, 8'h5A, 8'hA5, 8'h3C, 2, 1, 2, 0, 8'hA5, 8'h3C, 8'h00);
      tab[5] = mk(3'b001, 8'h7E, 8'h81, 8'h42, 1, 0, 0, 0, 8'h7E, 8'h00, 8'h00);
      tab[6] = mk(3'b100, 8'h13, 8'h57, 8'h99, 1, 2, 0, 0, 8'h99, 8'h00, 8'h00);
      tab[7] = mk(3'b011, 8'hC3, 8'h3C, 8'h66, 2, 0, 1, 0, 8'hC3, 8'h3C, 8'h00);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      d0 = 8'h0; d1 = 8'h0; d2 = 8'h0; lane_mask = 3'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_outputs", 32'({out_data, out_lane, out_last}), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst = 1'b0;

      // Reset in the middle of a frame aborts it asynchronously.
      send(mk(3'b111, 8'h11, 8'h22, 8'h33, 3, 0, 1, 2, 8'h11, 8'h22, 8'h33));
      idle_in();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_outputs", 32'({out_data, out_lane, out_last}), 0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 0);
      sb.delete();
      exp_frames = 0;
      exp_drops  = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_frame_after", 32'(frame_cnt), 0);

      // Full frame: first byte the cycle after capture, three consecutive bytes.
      send(tab[0]);
      idle_in();
      chk("ff_latency", 32'({out_valid, out_lane}), 32'({1'b1, 2'd0}));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ff_valid", 32'(out_valid), 1);
         chk("ff_last", 32'(out_last), (i == 2) ? 1 : 0);
      end
      @(negedge clk);
      chk("ff_done_idle", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("ff_frame_cnt", 32'(frame_cnt), exp_frames);

      // Masked lanes.
      send(tab[1]); idle_in(); drain();
      send(tab[2]); idle_in(); drain();
      chk("mask_frame_cnt", 32'(frame_cnt), exp_frames);

      // Backpressure mid-frame.
      send(mk(3'b111, 8'hA1, 8'hB2, 8'hC3, 3, 0, 1, 2, 8'hA1, 8'hB2, 8'hC3));
      idle_in();
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_lane", 32'({out_valid, out_lane, out_data}), 32'({1'b1, 2'd1, 8'hB2}));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain();
      chk("bp_frame_cnt", 32'(frame_cnt), exp_frames);

      // Back-to-back capture on the last handshake, then a drop chained the same way.
      send(mk(3'b111, 8'h21, 8'h32, 8'h43, 3, 0, 1, 2, 8'h21, 8'h32, 8'h43));
      send(mk(3'b111, 8'h54, 8'h65, 8'h76, 3, 0, 1, 2, 8'h54, 8'h65, 8'h76));
      chk("b2b_no_bubble", 32'({out_valid, out_lane, out_data}), 32'({1'b1, 2'd0, 8'h54}));
      send(mk(3'b000, 8'h87, 8'h98, 8'hA9, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
      idle_in();
      chk("b2b_drop_idle", 32'(out_valid), 0);
      drain();
      chk("b2b_drop_cnt", 32'(drop_cnt), exp_drops);
      chk("b2b_frame_cnt", 32'(frame_cnt), exp_frames);
      chk("b2b_drop_cnt_w", 32'(drop_cnt_w), exp_drops % 4);

      // Table vectors, chained without idle gaps.
      for (int i = 0; i < 8; i++) send(tab[i]);
      idle_in();
      drain();
      chk("tab_frame_cnt", 32'(frame_cnt), exp_frames);
      chk("tab_drop_cnt", 32'(drop_cnt), exp_drops);

      // Counter wrap on the CNT_W=2 instance.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_frames = 0;
      exp_drops  = 0;
      for (int i = 0; i < 5; i++) begin
         send(tab[5]);
         idle_in();
         drain();
      end
      chk("wrap_frame_cnt_w", 32'(frame_cnt_w), 1);
      chk("wrap_frame_cnt", 32'(frame_cnt), exp_frames);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
